// File: rtl/regfile_wb_arbiter.sv
// Register file write-port arbiter for the ALU and load writeback paths, with a
// busy scoreboard that lets decode detect RAW and WAW hazards on in-flight destinations.
module regfile_wb_arbiter #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32,
    localparam int PW   = $clog2(NREGS)
) (
    input  logic            clk,
    input  logic            rst_n,

    input  logic            alu_valid,
    output logic            alu_ready,
    input  logic [PW-1:0]   alu_rd,
    input  logic [XLEN-1:0] alu_data,

    input  logic            mem_valid,
    output logic            mem_ready,
    input  logic [PW-1:0]   mem_rd,
    input  logic [XLEN-1:0] mem_data,

    input  logic            issue_valid,
    input  logic [PW-1:0]   issue_rd,
    output logic            issue_ready,
    input  logic [PW-1:0]   rs1_ptr,
    input  logic [PW-1:0]   rs2_ptr,
    output logic            rs1_busy,
    output logic            rs2_busy,

    output logic            rf_write_en,
    output logic [PW-1:0]   rf_write_ptr,
    output logic [XLEN-1:0] rf_write_data
);

    typedef enum logic {
        GRANT_ALU = 1'b0,
        GRANT_MEM = 1'b1
    } grant_e;

    grant_e            last_grant_q, last_grant_d;
    logic              wr_en_q, wr_en_d;
    logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [XLEN-1:0]   wr_data_q, wr_data_d;
    logic [NREGS-1:0]  busy_q, busy_d;

    logic              alu_xfer, mem_xfer, xfer;
    logic [PW-1:0]     xfer_rd;
    logic [XLEN-1:0]   xfer_data;
    logic              issue_set;

    // Both contending: the requester that did not win last time goes next.
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        alu_ready = 1'b0;
        mem_ready = 1'b0;
        if (alu_valid && mem_valid) begin
            if (last_grant_q == GRANT_MEM) alu_ready = 1'b1;
            else                           mem_ready = 1'b1;
        end else begin
            alu_ready = alu_valid;
            mem_ready = mem_valid;
        end
    end

    assign alu_xfer  = alu_valid && alu_ready;
    assign mem_xfer  = mem_valid && mem_ready;
    assign xfer      = alu_xfer || mem_xfer;
    assign xfer_rd   = mem_xfer ? mem_rd   : alu_rd;
    assign xfer_data = mem_xfer ? mem_data : alu_data;

    always_comb begin
        last_grant_d = last_grant_q;
        if (alu_xfer)      last_grant_d = GRANT_ALU;
        else if (mem_xfer) last_grant_d = GRANT_MEM;
    end

    // x0 transfers complete the handshake but never raise the write enable.
    always_comb begin
        wr_en_d   = 1'b0;
        wr_ptr_d  = wr_ptr_q;
        wr_data_d = wr_data_q;
        if (xfer) begin
            wr_en_d   = (xfer_rd != '0);
            wr_ptr_d  = xfer_rd;
            wr_data_d = xfer_data;
        end
    end

    // Clear on the edge the register file captures the value; set for new issues.
    // issue_ready guarantees the set and clear never hit the same bit.
    assign issue_ready = !busy_q[issue_rd];
    assign issue_set   = issue_valid && issue_ready && (issue_rd != '0);

    always_comb begin
        busy_d = busy_q;
        if (wr_en_q)   busy_d[wr_ptr_q] = 1'b0;
        if (issue_set) busy_d[issue_rd] = 1'b1;
        busy_d[0] = 1'b0;
    end

    assign rs1_busy = (rs1_ptr != '0) && busy_q[rs1_ptr];
    assign rs2_busy = (rs2_ptr != '0) && busy_q[rs2_ptr];

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            last_grant_q <= GRANT_MEM;
            wr_en_q      <= 1'b0;
            wr_ptr_q     <= '0;
            wr_data_q    <= '0;
            busy_q       <= '0;
        end else begin
            last_grant_q <= last_grant_d;
            wr_en_q      <= wr_en_d;
            wr_ptr_q     <= wr_ptr_d;
            wr_data_q    <= wr_data_d;
            busy_q       <= busy_d;
        end
    end

    assign rf_write_en   = wr_en_q;
    assign rf_write_ptr  = wr_ptr_q;
    assign rf_write_data = wr_data_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: reset, single write, round-robin contention,
// x0 drop, RAW/WAW scoreboard, simultaneous set/clear and mid-operation reset.
module tb_regfile_wb_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        alu_valid, alu_ready;
    logic [4:0]  alu_rd;
    logic [31:0] alu_data;
    logic        mem_valid, mem_ready;
    logic [4:0]  mem_rd;
    logic [31:0] mem_data;
    logic        issue_valid, issue_ready;
    logic [4:0]  issue_rd, rs1_ptr, rs2_ptr;
    logic        rs1_busy, rs2_busy;
    logic        rf_write_en;
    logic [4:0]  rf_write_ptr;
    logic [31:0] rf_write_data;

    int checks   = 0;
    int failures = 0;

    regfile_wb_arbiter #(.XLEN(32), .NREGS(32)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .alu_valid    (alu_valid),
        .alu_ready    (alu_ready),
        .alu_rd       (alu_rd),
        .alu_data     (alu_data),
        .mem_valid    (mem_valid),
        .mem_ready    (mem_ready),
        .mem_rd       (mem_rd),
        .mem_data     (mem_data),
        .issue_valid  (issue_valid),
        .issue_rd     (issue_rd),
        .issue_ready  (issue_ready),
        .rs1_ptr      (rs1_ptr),
        .rs2_ptr      (rs2_ptr),
        .rs1_busy     (rs1_busy),
        .rs2_busy     (rs2_busy),
        .rf_write_en  (rf_write_en),
        .rf_write_ptr (rf_write_ptr),
        .rf_write_data(rf_write_data)
    );

    always #5 clk = ~clk;

    // Advance to 1 time unit after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        int busy_hits;
        rst_n = 1'b0;
        alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'hCAFE_0001;
        for (int c = 0; c < 2; c++) begin
            step();
            checks++;
            if (alu_ready !== 1'b1) begin
                failures++; $display("FAIL reset_alu_ready cyc%0d: got %b want 1", c, alu_ready);
            end
            checks++;
            if (rf_write_en !== 1'b0) begin
                failures++; $display("FAIL reset_wr_en cyc%0d: got %b want 0", c, rf_write_en);
            end
        end
        checks++;
        if (rf_write_ptr !== 5'd0 || rf_write_data !== 32'd0) begin
            failures++; $display("FAIL reset_ptr_data: got %0d/%h want 0/0", rf_write_ptr, rf_write_data);
        end
        busy_hits = 0;
        for (int r = 0; r < 32; r++) begin
            rs1_ptr = 5'(r);
            #1;
            if (rs1_busy !== 1'b0) busy_hits++;
        end
        checks++;
        if (busy_hits != 0) begin
            failures++; $display("FAIL reset_busy: got %0d busy regs want 0", busy_hits);
        end
        rst_n = 1'b1;
        mem_valid = 1'b1; mem_rd = 5'd6; mem_data = 32'hCAFE_0002;
        #1;
        checks++;
        if (alu_ready !== 1'b1 || mem_ready !== 1'b0) begin
            failures++; $display("FAIL reset_first_contention: got alu=%b mem=%b want 1/0", alu_ready, mem_ready);
        end
        alu_valid = 1'b0; mem_valid = 1'b0;
        step();
        checks++;
        if (rf_write_en !== 1'b0) begin
            failures++; $display("FAIL reset_idle_wr_en: got %b want 0", rf_write_en);
        end
    endtask

    task automatic test_single_alu();
        issue_valid = 1'b1; issue_rd = 5'd5;
        #1;
        checks++;
        if (issue_ready !== 1'b1) begin
            failures++; $display("FAIL single_issue_ready: got %b want 1", issue_ready);
        end
        step();
        issue_valid = 1'b0; rs1_ptr = 5'd5;
        alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'hDEAD_BEEF;
        #1;
        checks++;
        if (rs1_busy !== 1'b1) begin
            failures++; $display("FAIL single_rs1_busy_before: got %b want 1", rs1_busy);
        end
        checks++;
        if (alu_ready !== 1'b1 || mem_ready !== 1'b0) begin
            failures++; $display("FAIL single_ready: got alu=%b mem=%b want 1/0", alu_ready, mem_ready);
        end
        step();
        alu_valid = 1'b0;
        #1;
        checks++;
        if (rf_write_en !== 1'b1 || rf_write_ptr !== 5'd5 || rf_write_data !== 32'hDEAD_BEEF) begin
            failures++; $display("FAIL single_write: got en=%b ptr=%0d data=%h want 1/5/deadbeef",
                                 rf_write_en, rf_write_ptr, rf_write_data);
        end
        checks++;
        if (rs1_busy !== 1'b1) begin
            failures++; $display("FAIL single_rs1_busy_during_write: got %b want 1", rs1_busy);
        end
        step();
        checks++;
        if (rf_write_en !== 1'b0 || rs1_busy !== 1'b0) begin
            failures++; $display("FAIL single_after: got en=%b rs1_busy=%b want 0/0", rf_write_en, rs1_busy);
        end
    endtask

    task automatic test_x0_drop();
        mem_valid = 1'b1; mem_rd = 5'd0; mem_data = 32'h1234_5678;
        issue_valid = 1'b1; issue_rd = 5'd12;
        rs1_ptr = 5'd12; rs2_ptr = 5'd0;
        #1;
        checks++;
        if (mem_ready !== 1'b1 || alu_ready !== 1'b0) begin
            failures++; $display("FAIL x0_ready: got mem=%b alu=%b want 1/0", mem_ready, alu_ready);
        end
        step();
        mem_valid = 1'b0; issue_valid = 1'b0;
        #1;
        checks++;
        if (rf_write_en !== 1'b0) begin
            failures++; $display("FAIL x0_wr_en: got %b want 0", rf_write_en);
        end
        checks++;
        if (rs1_busy !== 1'b1 || rs2_busy !== 1'b0) begin
            failures++; $display("FAIL x0_scoreboard: got rs1=%b rs2=%b want 1/0", rs1_busy, rs2_busy);
        end
        step();
        checks++;
        if (rf_write_en !== 1'b0 || rs1_busy !== 1'b1) begin
            failures++; $display("FAIL x0_after: got en=%b rs1_busy=%b want 0/1", rf_write_en, rs1_busy);
        end
    endtask

    task automatic test_contention();
        logic [4:0]  a_rd   [2] = '{5'd1, 5'd2};
        logic [31:0] a_data [2] = '{32'hA000_0001, 32'hA000_0002};
        logic [4:0]  m_rd   [2] = '{5'd3, 5'd4};
        logic [31:0] m_data [2] = '{32'hB000_0003, 32'hB000_0004};
        bit          exp_mem [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
        logic [4:0]  exp_rd  [4] = '{5'd1, 5'd3, 5'd2, 5'd4};
        logic [31:0] exp_dat [4] = '{32'hA000_0001, 32'hB000_0003, 32'hA000_0002, 32'hB000_0004};
        int ai = 0;
        int mi = 0;
        for (int c = 0; c < 4; c++) begin
            alu_valid = (ai < 2);
            if (ai < 2) begin alu_rd = a_rd[ai]; alu_data = a_data[ai]; end
            mem_valid = (mi < 2);
            if (mi < 2) begin mem_rd = m_rd[mi]; mem_data = m_data[mi]; end
            #1;
            checks++;
            if (alu_ready !== !exp_mem[c] || mem_ready !== exp_mem[c]) begin
                failures++; $display("FAIL contention_grant cyc%0d: got alu=%b mem=%b want mem_win=%b",
                                     c, alu_ready, mem_ready, exp_mem[c]);
            end
            step();
            if (exp_mem[c]) mi++; else ai++;
            checks++;
            if (rf_write_en !== 1'b1 || rf_write_ptr !== exp_rd[c] || rf_write_data !== exp_dat[c]) begin
                failures++; $display("FAIL contention_write cyc%0d: got en=%b ptr=%0d data=%h want 1/%0d/%h",
                                     c, rf_write_en, rf_write_ptr, rf_write_data, exp_rd[c], exp_dat[c]);
            end
        end
        alu_valid = 1'b0; mem_valid = 1'b0;
        step();
        checks++;
        if (rf_write_en !== 1'b0) begin
            failures++; $display("FAIL contention_idle: got %b want 0", rf_write_en);
        end
    endtask

    task automatic test_waw_raw();
        issue_valid = 1'b1; issue_rd = 5'd7; rs2_ptr = 5'd7;
        #1;
        checks++;
        if (issue_ready !== 1'b1 || rs2_busy !== 1'b0) begin
            failures++; $display("FAIL waw_first_issue: got ready=%b rs2=%b want 1/0", issue_ready, rs2_busy);
        end
        step();
        checks++;
        if (rs2_busy !== 1'b1 || issue_ready !== 1'b0) begin
            failures++; $display("FAIL waw_hazard: got rs2=%b ready=%b want 1/0", rs2_busy, issue_ready);
        end
        step();
        issue_valid = 1'b0;
        mem_valid = 1'b1; mem_rd = 5'd7; mem_data = 32'h0000_0077;
        #1;
        checks++;
        if (mem_ready !== 1'b1 || rs2_busy !== 1'b1) begin
            failures++; $display("FAIL waw_mem_ready: got ready=%b rs2=%b want 1/1", mem_ready, rs2_busy);
        end
        step();
        mem_valid = 1'b0;
        #1;
        checks++;
        if (rf_write_en !== 1'b1 || rf_write_ptr !== 5'd7 || issue_ready !== 1'b0) begin
            failures++; $display("FAIL waw_commit: got en=%b ptr=%0d ready=%b want 1/7/0",
                                 rf_write_en, rf_write_ptr, issue_ready);
        end
        step();
        checks++;
        if (issue_ready !== 1'b1 || rs2_busy !== 1'b0) begin
            failures++; $display("FAIL waw_released: got ready=%b rs2=%b want 1/0", issue_ready, rs2_busy);
        end
    endtask

    task automatic test_set_clear();
        issue_valid = 1'b1; issue_rd = 5'd9;
        step();
        issue_valid = 1'b0;
        alu_valid = 1'b1; alu_rd = 5'd9; alu_data = 32'h0000_0099;
        step();
        alu_valid = 1'b0;
        issue_valid = 1'b1; issue_rd = 5'd3;
        #1;
        checks++;
        if (rf_write_en !== 1'b1 || rf_write_ptr !== 5'd9 || issue_ready !== 1'b1) begin
            failures++; $display("FAIL setclr_setup: got en=%b ptr=%0d ready=%b want 1/9/1",
                                 rf_write_en, rf_write_ptr, issue_ready);
        end
        step();
        issue_valid = 1'b0;
        rs1_ptr = 5'd3; rs2_ptr = 5'd9;
        #1;
        checks++;
        if (rs1_busy !== 1'b1 || rs2_busy !== 1'b0) begin
            failures++; $display("FAIL setclr_result: got busy3=%b busy9=%b want 1/0", rs1_busy, rs2_busy);
        end
    endtask

    task automatic test_mid_reset();
        alu_valid = 1'b1; alu_rd = 5'd20; alu_data = 32'h0000_2020;
        step();
        alu_valid = 1'b0;
        rst_n = 1'b0;
        step();
        rs1_ptr = 5'd12; rs2_ptr = 5'd3;
        #1;
        checks++;
        if (rf_write_en !== 1'b0 || rf_write_ptr !== 5'd0 || rf_write_data !== 32'd0) begin
            failures++; $display("FAIL midreset_outputs: got en=%b ptr=%0d data=%h want 0/0/0",
                                 rf_write_en, rf_write_ptr, rf_write_data);
        end
        checks++;
        if (rs1_busy !== 1'b0 || rs2_busy !== 1'b0) begin
            failures++; $display("FAIL midreset_busy: got busy12=%b busy3=%b want 0/0", rs1_busy, rs2_busy);
        end
        rst_n = 1'b1;
        alu_valid = 1'b1; mem_valid = 1'b1;
        #1;
        checks++;
        if (alu_ready !== 1'b1 || mem_ready !== 1'b0) begin
            failures++; $display("FAIL midreset_alu_first: got alu=%b mem=%b want 1/0", alu_ready, mem_ready);
        end
        alu_valid = 1'b0; mem_valid = 1'b0;
        step();
    endtask

    initial begin
        rst_n = 1'b0;
        alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
        mem_valid = 1'b0; mem_rd = '0; mem_data = '0;
        issue_valid = 1'b0; issue_rd = '0;
        rs1_ptr = '0; rs2_ptr = '0;
        test_reset();
        test_single_alu();
        test_x0_drop();
        test_contention();
        test_waw_raw();
        test_set_clear();
        test_mid_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
